// File: rtl/fc_pkg.sv
// Shared types and constants for the fully-connected weight packer.
package fc_pkg;

  // Load sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } fc_state_e;

  // Default limits for fan-in per neuron and number of neurons.
  localparam int FC_NW_MAX  = 400;
  localparam int FC_NUM_MAX = 120;

  // Number of bits needed to index 'value' items (0 for value <= 1).
  function automatic int fc_clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/fc_out_reg.sv
// Single-entry output holding register: a loaded payload stays on dout,
// with en high, until the consumer acknowledges it.
module fc_out_reg #(
  parameter int            PW      = 8,
  parameter logic [PW-1:0] RST_VAL = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [PW-1:0] din,
  input  logic          ack,
  output logic          en,
  output logic [PW-1:0] dout
);

  // Capture a new payload, or drop the current one once it is accepted;
  // a load in the same cycle as an ack keeps en asserted.
  always_ff @(posedge clk) begin
    if (rst) begin
      en   <= 1'b0;
      dout <= RST_VAL;
    end else if (load) begin
      en   <= 1'b1;
      dout <= din;
    end else if (ack) begin
      en   <= 1'b0;
    end
  end

endmodule

// File: rtl/fc_weight_packer.sv
// Packs a stream of scalar weights into LANES-wide words, neuron by neuron,
// tagging each word with its index, neuron number and last-of-neuron flag.
module fc_weight_packer
  import fc_pkg::*;
#(
  parameter int WD      = 8,
  parameter int LANES   = 4,
  parameter int NW_MAX  = FC_NW_MAX,
  parameter int NUM_MAX = FC_NUM_MAX
) (
  input  logic                i_sclk,
  input  logic                i_rst,
  input  logic [8:0]          i_cfg_nw,
  input  logic [7:0]          i_cfg_num,
  input  logic                i_start,
  input  logic                i_w_valid,
  input  logic [WD-1:0]       i_w_data,
  output logic                o_w_ready,
  output logic                o_w_en,
  input  logic                i_w_ack,
  output logic [LANES*WD-1:0] o_weight,
  output logic [7:0]          o_w_addr,
  output logic [7:0]          o_w_num,
  output logic                o_w_last,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_err
);

  localparam int LW = (fc_clog2(LANES) < 1) ? 1 : fc_clog2(LANES);
  localparam int DW = LANES * WD;
  localparam int PW = DW + 17;
  localparam logic [PW-1:0] PAY_RST   = {1'b0, 8'd1, 8'd0, {DW{1'b0}}};
  localparam logic [31:0]   NW_MAX_U  = NW_MAX;
  localparam logic [31:0]   NUM_MAX_U = NUM_MAX;

  fc_state_e     state;
  fc_state_e     state_next;
  logic [8:0]    cfg_nw;
  logic [7:0]    cfg_num;
  logic [8:0]    cnt_nw;
  logic [7:0]    cnt_num;
  logic [7:0]    cnt_word;
  logic [LW-1:0] cnt_lane;
  logic [DW-1:0] pack;
  logic [DW-1:0] word_next;
  logic [PW-1:0] pay_in;
  logic [PW-1:0] pay_out;
  logic          err_flag;
  logic          cfg_ok;
  logic          accept;
  logic          last_lane;
  logic          last_nw;
  logic          final_neuron;
  logic          complete;
  logic          final_weight;

  assign cfg_ok = (i_cfg_nw != 9'd0) && ({23'd0, i_cfg_nw} <= NW_MAX_U) &&
                  (i_cfg_num != 8'd0) && ({24'd0, i_cfg_num} <= NUM_MAX_U);

  assign accept       = i_w_valid && o_w_ready;
  assign last_lane    = (cnt_lane == LW'(LANES - 1));
  assign last_nw      = (cnt_nw == (cfg_nw - 9'd1));
  assign final_neuron = (cnt_num == cfg_num);
  assign complete     = accept && (last_lane || last_nw);
  assign final_weight = accept && last_nw && final_neuron;

  // Pack register with the incoming weight dropped into the current lane.
  always_comb begin
    word_next = pack;
    for (int i = 0; i < LANES; i++) begin
      if (cnt_lane == LW'(i)) begin
        word_next[i*WD +: WD] = i_w_data;
      end else begin
        word_next[i*WD +: WD] = pack[i*WD +: WD];
      end
    end
  end

  assign pay_in = {last_nw, cnt_num, cnt_word, word_next};

  // State register.
  always_ff @(posedge i_sclk) begin
    if (i_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: start only from IDLE, drain after the last weight.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (i_start && cfg_ok) begin
          state_next = ST_RUN;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (final_weight) begin
          state_next = ST_DRAIN;
        end else begin
          state_next = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (o_w_en && i_w_ack) begin
          state_next = ST_IDLE;
        end else begin
          state_next = ST_DRAIN;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Handshake and status outputs derived from state and the output register.
  always_comb begin
    o_w_ready = (state == ST_RUN) && (!o_w_en || i_w_ack);
    o_busy    = (state != ST_IDLE);
    o_done    = (state == ST_DRAIN) && o_w_en && i_w_ack;
  end

  // Configuration latch, error flag, lane/weight/word/neuron counters and
  // pack register; the pack register clears whenever a word completes so
  // unfilled lanes of a short final word read as zero.
  always_ff @(posedge i_sclk) begin
    if (i_rst) begin
      cfg_nw   <= 9'd0;
      cfg_num  <= 8'd0;
      cnt_nw   <= 9'd0;
      cnt_num  <= 8'd1;
      cnt_word <= 8'd0;
      cnt_lane <= '0;
      pack     <= '0;
      err_flag <= 1'b0;
    end else if ((state == ST_IDLE) && i_start) begin
      if (cfg_ok) begin
        cfg_nw   <= i_cfg_nw;
        cfg_num  <= i_cfg_num;
        cnt_nw   <= 9'd0;
        cnt_num  <= 8'd1;
        cnt_word <= 8'd0;
        cnt_lane <= '0;
        pack     <= '0;
        err_flag <= 1'b0;
      end else begin
        err_flag <= 1'b1;
      end
    end else if (accept) begin
      if (complete) begin
        pack     <= '0;
        cnt_lane <= '0;
      end else begin
        pack     <= word_next;
        cnt_lane <= cnt_lane + LW'(1);
      end
      if (last_nw) begin
        cnt_nw   <= 9'd0;
        cnt_word <= 8'd0;
        if (!final_neuron) begin
          cnt_num <= cnt_num + 8'd1;
        end
      end else begin
        cnt_nw <= cnt_nw + 9'd1;
        if (complete) begin
          cnt_word <= cnt_word + 8'd1;
        end
      end
    end
  end

  assign o_err = err_flag;

  fc_out_reg #(
    .PW      (PW),
    .RST_VAL (PAY_RST)
  ) u_out_reg (
    .clk  (i_sclk),
    .rst  (i_rst),
    .load (complete),
    .din  (pay_in),
    .ack  (i_w_ack),
    .en   (o_w_en),
    .dout (pay_out)
  );

  assign {o_w_last, o_w_num, o_w_addr, o_weight} = pay_out;

endmodule

// File: tb/tb_fc_weight_packer.sv
// Self-checking bench for fc_weight_packer: a queue-based model of the
// expected word sequence, checked on every accepted output word.
module tb_fc_weight_packer;

  localparam int WD    = 8;
  localparam int LANES = 4;
  localparam int DW    = WD * LANES;

  typedef struct packed {
    logic [DW-1:0] weight;
    logic [7:0]    addr;
    logic [7:0]    num;
    logic          last;
  } exp_t;

  logic          i_sclk;
  logic          i_rst;
  logic [8:0]    i_cfg_nw;
  logic [7:0]    i_cfg_num;
  logic          i_start;
  logic          i_w_valid;
  logic [WD-1:0] i_w_data;
  logic          o_w_ready;
  logic          o_w_en;
  logic          i_w_ack;
  logic [DW-1:0] o_weight;
  logic [7:0]    o_w_addr;
  logic [7:0]    o_w_num;
  logic          o_w_last;
  logic          o_busy;
  logic          o_done;
  logic          o_err;

  int          n_tests = 0;
  int          n_fail  = 0;
  exp_t        exp_q[$];
  logic [7:0]  wq[$];
  bit          chk_en    = 1'b0;
  bit          prev_hold = 1'b0;
  logic [48:0] prev_pay;
  exp_t        e_cur;

  fc_weight_packer #(.WD(WD), .LANES(LANES)) dut (
    .i_sclk    (i_sclk),
    .i_rst     (i_rst),
    .i_cfg_nw  (i_cfg_nw),
    .i_cfg_num (i_cfg_num),
    .i_start   (i_start),
    .i_w_valid (i_w_valid),
    .i_w_data  (i_w_data),
    .o_w_ready (o_w_ready),
    .o_w_en    (o_w_en),
    .i_w_ack   (i_w_ack),
    .o_weight  (o_weight),
    .o_w_addr  (o_w_addr),
    .o_w_num   (o_w_num),
    .o_w_last  (o_w_last),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_err     (o_err)
  );

  initial begin
    i_sclk = 1'b0;
    forever #5 i_sclk = ~i_sclk;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected words: neuron n, word k, lane j holds weight n*nw + k*LANES + j, zero past fan-in.
  function automatic void build_expected(input int nw, input int num);
    int   nwords;
    int   idx;
    exp_t e;
    nwords = (nw + LANES - 1) / LANES;
    exp_q.delete();
    for (int n = 0; n < num; n++) begin
      for (int k = 0; k < nwords; k++) begin
        e.weight = '0;
        for (int j = 0; j < LANES; j++) begin
          idx = k * LANES + j;
          if (idx < nw) e.weight[j*WD +: WD] = wq[n*nw + idx];
        end
        e.addr = 8'(k);
        e.num  = 8'(n + 1);
        e.last = (k == nwords - 1);
        exp_q.push_back(e);
      end
    end
  endfunction

  // Per-cycle checker: accepted words against the model, stability while stalled.
  always @(negedge i_sclk) begin
    if (chk_en && !i_rst) begin
      if (prev_hold) begin
        check("hold_en", 64'(o_w_en), 64'd1);
        check("hold_payload", 64'({o_w_last, o_w_num, o_w_addr, o_weight}), 64'(prev_pay));
      end
      if (o_w_en && i_w_ack) begin
        if (exp_q.size() == 0) begin
          check("extra_word", 64'(o_w_en), 64'd0);
        end else begin
          e_cur = exp_q.pop_front();
          check("word_data", 64'(o_weight), 64'(e_cur.weight));
          check("word_addr", 64'(o_w_addr), 64'(e_cur.addr));
          check("word_num",  64'(o_w_num),  64'(e_cur.num));
          check("word_last", 64'(o_w_last), 64'(e_cur.last));
          check("word_done", 64'(o_done),   64'(exp_q.size() == 0));
        end
      end else begin
        check("done_quiet", 64'(o_done), 64'd0);
      end
      prev_hold = o_w_en && !i_w_ack;
      prev_pay  = {o_w_last, o_w_num, o_w_addr, o_weight};
    end else begin
      prev_hold = 1'b0;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_w_en"},  64'(o_w_en),    64'd0);
    check({tag, "_weight"},64'(o_weight),  64'd0);
    check({tag, "_addr"},  64'(o_w_addr),  64'd0);
    check({tag, "_num"},   64'(o_w_num),   64'd1);
    check({tag, "_last"},  64'(o_w_last),  64'd0);
    check({tag, "_ready"}, 64'(o_w_ready), 64'd0);
    check({tag, "_busy"},  64'(o_busy),    64'd0);
    check({tag, "_done"},  64'(o_done),    64'd0);
    check({tag, "_err"},   64'(o_err),     64'd0);
  endtask

  // Hand-computed expectations that pin the model itself.
  task automatic pin_model();
    int exp_addr[4] = '{0, 1, 0, 1};
    int exp_num[4]  = '{1, 1, 2, 2};
    int exp_last[4] = '{0, 1, 0, 1};
    wq.delete();
    for (int i = 0; i < 10; i++) wq.push_back(8'(i + 1));
    build_expected(10, 1);
    check("pin10_count", 64'(exp_q.size()), 64'd3);
    check("pin10_w0", 64'(exp_q[0].weight), 64'h04030201);
    check("pin10_w1", 64'(exp_q[1].weight), 64'h08070605);
    check("pin10_w2", 64'(exp_q[2].weight), 64'h00000a09);
    check("pin10_last2", 64'(exp_q[2].last), 64'd1);
    check("pin10_last0", 64'(exp_q[0].last), 64'd0);
    wq.delete();
    for (int i = 0; i < 16; i++) wq.push_back(8'(i + 1));
    build_expected(8, 2);
    check("pin8x2_count", 64'(exp_q.size()), 64'd4);
    for (int k = 0; k < 4; k++) begin
      check("pin8x2_addr", 64'(exp_q[k].addr), 64'(exp_addr[k]));
      check("pin8x2_num",  64'(exp_q[k].num),  64'(exp_num[k]));
      check("pin8x2_last", 64'(exp_q[k].last), 64'(exp_last[k]));
    end
    exp_q.delete();
  endtask

  // One full load. ack_mode: 0 random, 1 always, 2 held low for 5 cycles after first word.
  task automatic run_load(input int nw, input int num, input bit seq_data,
                          input int ack_mode, input int vpct, input int glitch_at);
    int total;
    int widx;
    int cyc;
    int limit;
    int hold_left;
    bit fin;
    bit first_seen;
    total = nw * num;
    wq.delete();
    for (int i = 0; i < total; i++) wq.push_back(seq_data ? 8'(i + 1) : 8'($urandom));
    build_expected(nw, num);
    i_cfg_nw  = 9'(nw);
    i_cfg_num = 8'(num);
    i_start   = 1'b1;
    @(posedge i_sclk); #1;
    i_start = 1'b0;
    check("start_busy", 64'(o_busy), 64'd1);
    check("start_err",  64'(o_err),  64'd0);
    widx = 0; cyc = 0; fin = 1'b0; first_seen = 1'b0; hold_left = 0;
    limit = 30 * total + 300;
    while (!fin && cyc < limit) begin
      i_w_valid = (widx < total) && ($urandom_range(99) < vpct);
      if (widx < total) i_w_data = wq[widx];
      else              i_w_data = 8'($urandom);
      case (ack_mode)
        1: i_w_ack = 1'b1;
        2: begin
          i_w_ack = (!first_seen || hold_left > 0) ? 1'b0 : 1'b1;
          if (first_seen && hold_left > 0) hold_left--;
        end
        default: i_w_ack = 1'($urandom % 2);
      endcase
      if (cyc == glitch_at) begin
        i_start = 1'b1; i_cfg_nw = 9'd3; i_cfg_num = 8'd3;
      end else begin
        i_start = 1'b0; i_cfg_nw = 9'(nw); i_cfg_num = 8'(num);
      end
      @(negedge i_sclk);
      if (i_w_valid && o_w_ready) widx++;
      if (ack_mode == 2) begin
        if (!first_seen && o_w_en) begin
          first_seen = 1'b1;
          hold_left  = 5;
        end
        if (o_w_en && !i_w_ack) check("stall_ready", 64'(o_w_ready), 64'd0);
      end
      if (o_done) fin = 1'b1;
      @(posedge i_sclk); #1;
      cyc++;
    end
    i_w_valid = 1'b0;
    i_w_ack   = 1'b0;
    i_start   = 1'b0;
    if (!fin) check("load_timeout", 64'(fin), 64'd1);
    check("weights_consumed", 64'(widx), 64'(total));
    check("model_drained", 64'(exp_q.size()), 64'd0);
    @(negedge i_sclk);
    check("end_busy", 64'(o_busy), 64'd0);
  endtask

  task automatic bad_start(input int nw, input int num, input string tag);
    i_cfg_nw  = 9'(nw);
    i_cfg_num = 8'(num);
    i_start   = 1'b1;
    @(posedge i_sclk); #1;
    i_start = 1'b0;
    @(negedge i_sclk);
    check({tag, "_err"},  64'(o_err),  64'd1);
    check({tag, "_busy"}, 64'(o_busy), 64'd0);
  endtask

  initial begin
    i_rst = 1'b1; i_cfg_nw = 9'd0; i_cfg_num = 8'd0; i_start = 1'b0;
    i_w_valid = 1'b0; i_w_data = 8'd0; i_w_ack = 1'b0;
    @(posedge i_sclk);
    @(negedge i_sclk);
    check_reset_outputs("rst");
    @(posedge i_sclk); #1;
    i_rst = 1'b0;

    pin_model();
    chk_en = 1'b1;

    // Sequential-data loads matching the hand-worked cases.
    run_load(10, 1, 1'b1, 1, 100, -1);
    run_load(8, 2, 1'b1, 1, 100, -1);

    // Consumer stall after the first word.
    run_load(12, 2, 1'b0, 2, 100, -1);

    // Invalid configurations, then a valid one clears the error.
    bad_start(0, 5, "cfg_nw0");
    bad_start(401, 5, "cfg_nw401");
    bad_start(5, 0, "cfg_num0");
    bad_start(5, 121, "cfg_num121");
    run_load(6, 2, 1'b0, 0, 80, -1);

    // Reset in the middle of a load, then a clean load.
    chk_en = 1'b0;
    i_cfg_nw = 9'd8; i_cfg_num = 8'd2; i_start = 1'b1;
    @(posedge i_sclk); #1;
    i_start = 1'b0; i_w_valid = 1'b1; i_w_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      i_w_data = 8'($urandom);
      @(posedge i_sclk); #1;
    end
    i_w_valid = 1'b0;
    i_rst = 1'b1;
    @(posedge i_sclk);
    @(negedge i_sclk);
    check_reset_outputs("midrst");
    i_rst = 1'b0; i_w_ack = 1'b0;
    @(posedge i_sclk); #1;
    chk_en = 1'b1;
    run_load(8, 2, 1'b0, 1, 100, -1);

    // Start pulse in the middle of a load is ignored.
    run_load(9, 3, 1'b0, 1, 100, 6);

    // Boundary fan-in and neuron counts.
    run_load(1, 120, 1'b0, 0, 90, -1);
    run_load(400, 2, 1'b0, 1, 100, -1);
    run_load(3, 1, 1'b0, 0, 70, -1);

    // Randomized loads.
    for (int r = 0; r < 6; r++) begin
      run_load($urandom_range(1, 40), $urandom_range(1, 5), 1'b0, 0,
               $urandom_range(40, 100), -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fc_weight_packer.md
FC_WEIGHT_PACKER -- requirements
Module: fc_weight_packer

Interface
REQ-001 Parameter WD, default 8, weight width in bits.
REQ-002 Parameter LANES, default 4, weights packed per output word.
REQ-003 Parameter NW_MAX, default 400, maximum fan-in per neuron.
REQ-004 Parameter NUM_MAX, default 120, maximum neuron count.
REQ-005 Ports: i_sclk in 1 clock; i_rst in 1 reset; one clock, reset synchronous and active-high.
REQ-006 Ports: i_cfg_nw in 9 fan-in; i_cfg_num in 8 neuron count; i_start in 1 load-start pulse.
REQ-007 Ports: i_w_valid in 1; i_w_data in WD scalar weight; o_w_ready out 1.
REQ-008 Ports: o_w_en out 1 word valid; i_w_ack in 1 consumer accept; o_weight out LANES*WD packed word, lane 0 in LSBs.
REQ-009 Ports: o_w_addr out 8 word index within neuron; o_w_num out 8 neuron number, 1-based; o_w_last out 1 last word of neuron.
REQ-010 Ports: o_busy out 1; o_done out 1 one-cycle pulse; o_err out 1 sticky config error.

Function
REQ-011 FSM states IDLE, RUN, DRAIN; IDLE->RUN on i_start with valid config; RUN->DRAIN when final weight of final neuron is accepted; DRAIN->IDLE when final word is accepted.
REQ-012 Config valid iff 1 <= i_cfg_nw <= NW_MAX and 1 <= i_cfg_num <= NUM_MAX; both latched on accepted i_start.
REQ-013 i_start with invalid config keeps IDLE and sets o_err; o_err clears on next i_start with valid config.
REQ-014 i_start while RUN or DRAIN is ignored; no state or counter change.
REQ-015 Input handshake: a weight is accepted when i_w_valid && o_w_ready; o_w_ready = (state==RUN) && (!o_w_en || i_w_ack).
REQ-016 Accepted weight is written into lane cnt_lane of the pack register; cnt_lane wraps 0..LANES-1.
REQ-017 Word completes when cnt_lane==LANES-1 or the weight is the last of its neuron (cnt_nw==cfg_nw-1).
REQ-018 Incomplete final word of a neuron: unfilled lanes are zero.
REQ-019 Completed word loads the output register the next cycle: o_w_en=1, one-cycle latency from completing beat.
REQ-020 o_weight, o_w_addr, o_w_num, o_w_last hold stable while o_w_en && !i_w_ack.
REQ-021 Output register clears o_w_en on i_w_ack unless a new word loads in the same cycle; then o_w_en stays 1.
REQ-022 cnt_nw counts 0..cfg_nw-1 per neuron and wraps to 0; o_w_addr counts words 0..ceil(cfg_nw/LANES)-1 and resets per neuron.
REQ-023 cnt_num starts at 1 and increments on each neuron wrap; it does not exceed cfg_num.
REQ-024 o_done pulses one cycle on the cycle the final word is accepted.
REQ-025 o_busy = (state != IDLE).
REQ-026 Counter widths: cnt_nw 9 bits, cnt_num 8 bits; no arithmetic overflow for legal configs.

Reset
REQ-027 i_rst high at a clock edge: state IDLE, all counters 0 except cnt_num=1, pack register 0.
REQ-028 Reset outputs: o_w_en=0, o_weight=0, o_w_addr=0, o_w_num=1, o_w_last=0, o_w_ready=0, o_busy=0, o_done=0, o_err=0.
REQ-029 Reset mid-load discards the partial word and any pending output word; no o_done.

Structure
REQ-030 Shared package fc_pkg holds the FSM state enum, a clog2 width function and the NW_MAX/NUM_MAX defaults.
REQ-031 Output register with hold/accept logic is one sub-module, fc_out_reg, parametrised by payload width.

Verification
REQ-032 LANES=4, cfg 8x2, continuous valid, i_w_ack=1 -> 4 words; addr 0,1,0,1; num 1,1,2,2; last on words 2 and 4; o_done with word 4.
REQ-033 cfg_nw=10, cfg_num=1, weights 1..10 -> words {4,3,2,1}, {8,7,6,5}, {0,0,10,9}, the third with last=1.
REQ-034 i_w_ack held 0 for 5 cycles after first word -> o_w_ready=0 after next completing beat; no data loss; outputs stable.
REQ-035 i_start with cfg_nw=0, then with cfg_nw=401 -> o_err=1, o_busy=0; then valid cfg -> o_err=0, o_busy=1.
REQ-036 i_rst asserted after 3 weights in RUN -> all outputs at reset values next cycle; a new load completes normally.
REQ-037 i_start pulsed during RUN -> config and counters unchanged; word sequence identical to the uninterrupted run.
